// File: rtl/crc_rx_pkg.sv
// Shared constants for the receive-side CRC checker: widths, generator
// polynomial low terms and the FSM state encoding.
package crc_rx_pkg;

  localparam int MSG_W     = 60;
  localparam int CNT_W     = 6;
  localparam int ERR_CNT_W = 8;

  localparam int CRC8_LEN  = 8;
  localparam int CRC5_LEN  = 5;

  // Generator polynomials with the implicit leading term dropped.
  localparam logic [7:0] CRC8_POLY = 8'h31;
  localparam logic [4:0] CRC5_POLY = 5'h0B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit of MSB-first polynomial division.
// sel = 0 selects CRC-8 over r[7:0]; sel = 1 selects CRC-5 over r[4:0].
module crc_lfsr_step
  import crc_rx_pkg::*;
(
  input  logic [7:0] r,
  input  logic       b,
  input  logic       sel,
  output logic [7:0] r_next
);

  always_comb begin
    r_next = '0;
    if (!sel) begin
      r_next = {r[6:0], b} ^ (r[7] ? CRC8_POLY : 8'h00);
    end else begin
      // The CRC-5 remainder lives in r[4:0]; the upper bits are held at zero.
      r_next = {3'b000, ({r[3:0], b} ^ (r[4] ? CRC5_POLY : 5'h00))};
    end
  end

endmodule

// File: rtl/crc_codeword_checker.sv
// Bit-serial CRC-8 / CRC-5 codeword checker: divides the whole 60-bit word
// MSB first, then presents the stripped payload, remainder and error flag.
module crc_codeword_checker
  import crc_rx_pkg::*;
#(
  parameter int MSG_W     = 60,
  parameter int CNT_W     = 6,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [MSG_W-1:0]     codeword,
  input  logic                 CRC,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [MSG_W-1:0]     out_payload,
  output logic                 crc_err,
  output logic [7:0]           remainder,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MSG_W - 1);

  logic [1:0]           state_q,   state_d;
  logic [MSG_W-1:0]     word_q,    word_d;
  logic                 sel_q,     sel_d;
  logic [7:0]           rem_q,     rem_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [7:0] step_r;
  logic       bit_in;
  logic       rem_nz;

  assign bit_in = word_q[cnt_q];
  assign rem_nz = (rem_q != 8'h00);

  crc_lfsr_step u_step (
    .r      (rem_q),
    .b      (bit_in),
    .sel    (sel_q),
    .r_next (step_r)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d  = codeword;
          sel_d   = CRC;
          rem_d   = 8'h00;
          cnt_d   = CNT_LOAD;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rem_d = step_r;
        if (cnt_q == '0) begin
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OUT: begin
        // Counter returns to its idle value so every word starts alike.
        cnt_d   = CNT_LOAD;
        state_d = ST_IDLE;
        if (rem_nz && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      sel_q     <= 1'b0;
      rem_q     <= 8'h00;
      cnt_q     <= CNT_LOAD;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign crc_err   = out_valid & rem_nz;
  assign remainder = out_valid ? rem_q : 8'h00;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    out_payload = '0;
    if (out_valid) begin
      if (rem_nz) begin
        out_payload = '1;
      end else if (sel_q) begin
        out_payload = word_q >> CRC5_LEN;
      end else begin
        out_payload = word_q >> CRC8_LEN;
      end
    end
  end

endmodule

// File: tb/tb_crc_codeword_checker.sv
// Self-checking bench for crc_codeword_checker: long-division reference model,
// per-cycle output scoreboard and directed literal checks.
module tb_crc_codeword_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [59:0] codeword;
  logic        CRC;
  logic        in_ready;
  logic        out_valid;
  logic [59:0] out_payload;
  logic        crc_err;
  logic [7:0]  remainder;
  logic [7:0]  err_cnt;

  crc_codeword_checker #(
    .MSG_W     (60),
    .CNT_W     (6),
    .ERR_CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .codeword    (codeword),
    .CRC         (CRC),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .crc_err     (crc_err),
    .remainder   (remainder),
    .err_cnt     (err_cnt)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc    = 0;
  int nvalid = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [59:0] exp_q[$];
  logic [7:0]  exp_rem_q[$];
  logic        exp_err_q[$];
  int          exp_t_q[$];
  int          model_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Remainder of codeword / G by plain polynomial long division.
  function automatic logic [7:0] model_rem(input logic [59:0] w, input logic sel);
    logic [59:0] x;
    logic [8:0]  g;
    int          d;
    x = w;
    g = sel ? 9'b000101011 : 9'b100110001;
    d = sel ? 5 : 8;
    for (int i = 59; i >= d; i--) begin
      if (x[i]) x = x ^ ({51'b0, g} << (i - d));
    end
    return x[7:0];
  endfunction

  function automatic logic [59:0] model_payload(input logic [59:0] w, input logic sel);
    if (model_rem(w, sel) != 8'h00) return {60{1'b1}};
    return sel ? (w >> 5) : (w >> 8);
  endfunction

  // ---------------- scoreboard / compare process ----------------
  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1) nvalid++;
    if (rst_n === 1'b1) begin
      check("in_ready", {63'b0, in_ready}, {63'b0, (exp_t_q.size() == 0)});
      check("err_cnt", {56'b0, err_cnt}, 64'(model_err));
      if (exp_t_q.size() != 0 && cyc == exp_t_q[0]) begin
        check("out_valid", {63'b0, out_valid}, 64'd1);
        check("out_payload", {4'b0, out_payload}, {4'b0, exp_q[0]});
        check("remainder", {56'b0, remainder}, {56'b0, exp_rem_q[0]});
        check("crc_err", {63'b0, crc_err}, {63'b0, exp_err_q[0]});
        if (exp_err_q[0] && model_err < 255) model_err++;
        void'(exp_q.pop_front());
        void'(exp_rem_q.pop_front());
        void'(exp_err_q.pop_front());
        void'(exp_t_q.pop_front());
      end else begin
        check("out_valid_idle", {63'b0, out_valid}, 64'd0);
        check("out_payload_idle", {4'b0, out_payload}, 64'd0);
        check("remainder_idle", {56'b0, remainder}, 64'd0);
        check("crc_err_idle", {63'b0, crc_err}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [59:0] cw, input logic sel);
    int guard;
    int t_out;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid = 1'b1;
    codeword = cw;
    CRC      = sel;
    t_out    = cyc + 61;
    @(posedge clk);
    exp_q.push_back(model_payload(cw, sel));
    exp_rem_q.push_back(model_rem(cw, sel));
    exp_err_q.push_back(model_rem(cw, sel) != 8'h00);
    exp_t_q.push_back(t_out);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_lit(input string name, input logic [59:0] pay, input logic [7:0] rem,
                          input logic err, input logic [7:0] cnt_after);
    bit seen;
    wait_out(seen);
    if (seen) begin
      check({name, "_payload"}, {4'b0, out_payload}, {4'b0, pay});
      check({name, "_remainder"}, {56'b0, remainder}, {56'b0, rem});
      check({name, "_crc_err"}, {63'b0, crc_err}, {63'b0, err});
    end
    @(negedge clk);
    check({name, "_err_cnt"}, {56'b0, err_cnt}, {56'b0, cnt_after});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [51:0] pay8 [4] = '{52'hABCDE_1234_5678, 52'h0_0000_0000_0001, 52'hF_FFFF_FFFF_FFFF, 52'h5_A5A5_A5A5_A5A5};
  logic [54:0] pay5 [4] = '{55'h12_3456_789A_BCDE, 55'h00_0000_0000_0002, 55'h7F_FFFF_FFFF_FFFF, 55'h2A_AAAA_5555_0F0F};

  initial begin
    int n0;
    logic [59:0] cw;
    bit seen;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    codeword = '0;
    CRC      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_payload", {4'b0, out_payload}, 64'd0);
    check("rst_remainder", {56'b0, remainder}, 64'd0);
    check("rst_crc_err", {63'b0, crc_err}, 64'd0);
    check("rst_err_cnt", {56'b0, err_cnt}, 64'd0);
    rst_n = 1'b1;

    // Pin the model to hand-computed values.
    check("model_rem_131", {56'b0, model_rem(60'h131, 1'b0)}, 64'd0);
    check("model_rem_130", {56'b0, model_rem(60'h130, 1'b0)}, 64'h01);
    check("model_rem_2b", {56'b0, model_rem(60'h2B, 1'b1)}, 64'd0);
    check("model_rem_2a", {56'b0, model_rem(60'h2A, 1'b1)}, 64'h01);
    check("model_pay_2b", {4'b0, model_payload(60'h2B, 1'b1)}, 64'd1);

    send_word(60'h131, 1'b0);
    wait_lit("crc8_ok", 60'h1, 8'h00, 1'b0, 8'd0);
    send_word(60'h2B, 1'b1);
    wait_lit("crc5_ok", 60'h1, 8'h00, 1'b0, 8'd0);
    send_word(60'h130, 1'b0);
    wait_lit("crc8_bad", {60{1'b1}}, 8'h01, 1'b1, 8'd1);
    send_word(60'h0, 1'b0);
    wait_lit("zero", 60'h0, 8'h00, 1'b0, 8'd1);
    send_word(60'h800_0000_0000_0000, 1'b1);
    wait_lit("top_bit", {60{1'b1}}, model_rem(60'h800_0000_0000_0000, 1'b1), 1'b1, 8'd2);

    // Model-built valid codewords plus single-bit corruptions.
    for (int i = 0; i < 4; i++) begin
      cw = {pay8[i], 8'h00};
      cw = cw | {52'b0, model_rem(cw, 1'b0)};
      send_word(cw, 1'b0);
      send_word(cw ^ (60'h1 << (i * 13)), 1'b0);
      cw = {pay5[i], 5'h00};
      cw = cw | {55'b0, model_rem(cw, 1'b1)[4:0]};
      send_word(cw, 1'b1);
      send_word(cw ^ (60'h1 << (i * 11 + 3)), 1'b1);
    end
    wait_out(seen);
    repeat (3) @(negedge clk);

    // in_valid while busy is ignored: exactly one strobe.
    n0 = nvalid;
    send_word(60'h131, 1'b0);
    repeat (4) @(negedge clk);
    in_valid = 1'b1; codeword = 60'h130; CRC = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (24) @(negedge clk);
    in_valid = 1'b1; codeword = 60'h2B; CRC = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("busy_one_strobe", 64'(nvalid - n0), 64'd1);

    // Reset mid-calculation aborts the word.
    send_word(60'h130, 1'b0);
    repeat (19) @(negedge clk);
    n0 = nvalid;
    rst_n = 1'b0;
    exp_q.delete(); exp_rem_q.delete(); exp_err_q.delete(); exp_t_q.delete();
    model_err = 0;
    #1;
    check("abort_in_ready", {63'b0, in_ready}, 64'd1);
    check("abort_err_cnt", {56'b0, err_cnt}, 64'd0);
    check("abort_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_strobe", 64'(nvalid - n0), 64'd0);
    check("abort_err_cnt_after", {56'b0, err_cnt}, 64'd0);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      send_word(60'h130, 1'b0);
      wait_out(seen);
      @(negedge clk);
      if (i >= 255) check("sat_err_cnt", {56'b0, err_cnt}, 64'd255);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
